// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
package fetch_pkg;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h8002_0000;
   typedef enum logic [1:0] {ACC_1W = 2'd0, ACC_4W = 2'd1, ACC_8W = 2'd2, ACC_16W = 2'd3} acc_size_t;
   localparam logic MEM_RD = 1'b1;
   localparam logic MEM_WR = 1'b0;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc, insn} pairs between fetch and decode.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output logic [1:0]   count
);
   fetch_entry_t e [2];
   logic rp, wp;
   assign head = e[rp];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         e <= '{default: '0};
         rp <= 1'b0;
         wp <= 1'b0;
         count <= 2'd0;
      end else if (flush) begin
         rp <= 1'b0;
         wp <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            e[wp] <= din;
            wp <= ~wp;
         end
         if (pop) rp <= ~rp;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-word read issue to memory and 2-entry delivery buffer to decode.
// At most two words are ever owed to decode (buffered plus in flight), so the buffer cannot overflow.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        mem_busy,
   input  logic [31:0] mem_data_in,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_out,
   output logic [1:0]  mem_access_size,
   output logic        mem_rd_wr,
   output logic        mem_enable,
   output logic        insn_valid,
   output logic [31:0] insn,
   output logic [31:0] insn_pc
);
   logic [31:0] pc, tag;
   logic inflight, pop, issue;
   logic [1:0] count;
   fetch_entry_t head, cap;
   assign insn_valid = count != 2'd0;
   assign pop = insn_valid & ~stall;
   assign issue = ~reset & ~redirect_valid & ~mem_busy
                  & (({1'b0, count} - {2'b0, pop} + {2'b0, inflight}) < 3'd2);
   assign mem_addr = pc;
   assign mem_enable = issue;
   assign mem_data_out = 32'd0;
   assign mem_access_size = ACC_1W;
   assign mem_rd_wr = MEM_RD;
   assign cap = '{pc: tag, insn: mem_data_in};
   assign insn = head.insn;
   assign insn_pc = head.pc;
   // A response arriving in a redirect cycle belongs to the old path and is dropped.
   fetch_buffer u_buf (
      .clk(clk), .reset(reset), .push(inflight & ~redirect_valid), .pop(pop),
      .flush(redirect_valid), .din(cap), .head(head), .count(count)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc <= PC_RESET;
         tag <= 32'd0;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         pc <= redirect_pc & 32'hFFFF_FFFC;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc <= pc + 32'd4;
            tag <= pc;
         end
      end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a stream-level model of expected fetch and delivery order.
module tb_fetch_unit;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0, mem_busy = 1'b0;
   logic [31:0] redirect_pc = 32'd0, mem_data_in = 32'd0;
   logic [31:0] mem_addr, mem_data_out, insn, insn_pc;
   logic [1:0] mem_access_size;
   logic mem_rd_wr, mem_enable, insn_valid;
   int tests = 0, fails = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .mem_busy(mem_busy), .mem_data_in(mem_data_in),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_access_size(mem_access_size),
      .mem_rd_wr(mem_rd_wr), .mem_enable(mem_enable), .insn_valid(insn_valid),
      .insn(insn), .insn_pc(insn_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0013_0593;
   endfunction

   // One-cycle-latency read-only memory.
   always @(posedge clk)
      if (mem_enable) mem_data_in <= mem_word(mem_addr);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Stream model: issues and deliveries each form a +4 address sequence restarted by reset/redirect.
   logic [31:0] exp_pc, exp_issue, hold_pc, hold_insn;
   logic hold;
   always @(negedge clk) begin
      if (reset) begin
         exp_pc = 32'h8002_0000;
         exp_issue = 32'h8002_0000;
         hold = 1'b0;
         chk("rst_enable", {31'd0, mem_enable}, 32'd0);
         chk("rst_valid", {31'd0, insn_valid}, 32'd0);
      end else begin
         chk("const_out", {mem_data_out, 29'd0, mem_access_size, mem_rd_wr}, {32'd0, 32'd1});
         if (hold) begin
            chk("hold_valid", {31'd0, insn_valid}, 32'd1);
            chk("hold_pc", insn_pc, hold_pc);
            chk("hold_insn", insn, hold_insn);
         end
         if (mem_busy || redirect_valid) chk("no_issue", {31'd0, mem_enable}, 32'd0);
         if (mem_enable) begin
            chk("issue_addr", mem_addr, exp_issue);
            exp_issue = exp_issue + 32'd4;
         end
         if (insn_valid && !stall) begin
            chk("deliver_pc", insn_pc, exp_pc);
            chk("deliver_insn", insn, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         hold = insn_valid && stall && !redirect_valid;
         hold_pc = insn_pc;
         hold_insn = insn;
         if (redirect_valid) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            exp_issue = redirect_pc & 32'hFFFF_FFFC;
         end
      end
   end

   logic [31:0] a;
   initial begin
      repeat (2) @(negedge clk);
      chk("reset_addr", mem_addr, 32'h8002_0000);
      chk("reset_insn", insn, 32'd0);
      chk("reset_insn_pc", insn_pc, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("c0_en", {31'd0, mem_enable}, 32'd1);
      chk("c0_addr", mem_addr, 32'h8002_0000);
      chk("c0_valid", {31'd0, insn_valid}, 32'd0);
      @(negedge clk);
      chk("c1_addr", mem_addr, 32'h8002_0004);
      chk("c1_valid", {31'd0, insn_valid}, 32'd0);
      @(negedge clk);
      chk("c2_valid", {31'd0, insn_valid}, 32'd1);
      chk("c2_pc", insn_pc, 32'h8002_0000);
      chk("c2_insn", insn, mem_word(32'h8002_0000));
      @(negedge clk);
      chk("c3_pc", insn_pc, 32'h8002_0004);
      repeat (3) @(negedge clk);
      // stall for three cycles mid-stream
      @(posedge clk); #1 stall = 1'b1;
      @(negedge clk);
      chk("s1_valid", {31'd0, insn_valid}, 32'd1);
      chk("s1_en", {31'd0, mem_enable}, 32'd0);
      @(negedge clk);
      chk("s2_en", {31'd0, mem_enable}, 32'd0);
      @(negedge clk);
      chk("s3_en", {31'd0, mem_enable}, 32'd0);
      @(posedge clk); #1 stall = 1'b0;
      repeat (4) @(negedge clk);
      // fill the buffer, then redirect
      @(posedge clk); #1 stall = 1'b1;
      @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h8002_0043;
      @(posedge clk); #1 redirect_valid = 1'b0; stall = 1'b0;
      @(negedge clk);
      chk("r1_valid", {31'd0, insn_valid}, 32'd0);
      chk("r1_addr", mem_addr, 32'h8002_0040);
      chk("r1_en", {31'd0, mem_enable}, 32'd1);
      @(negedge clk);
      chk("r2_valid", {31'd0, insn_valid}, 32'd0);
      chk("r2_addr", mem_addr, 32'h8002_0044);
      @(negedge clk);
      chk("r3_valid", {31'd0, insn_valid}, 32'd1);
      chk("r3_pc", insn_pc, 32'h8002_0040);
      @(negedge clk);
      chk("r4_pc", insn_pc, 32'h8002_0044);
      repeat (3) @(negedge clk);
      // memory busy for four cycles
      @(posedge clk); #1 mem_busy = 1'b1;
      @(negedge clk);
      a = mem_addr;
      chk("b1_en", {31'd0, mem_enable}, 32'd0);
      @(negedge clk);
      chk("b2_valid", {31'd0, insn_valid}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("b_addr_hold", mem_addr, a);
      end
      @(posedge clk); #1 mem_busy = 1'b0;
      repeat (4) @(negedge clk);
      // asynchronous reset between edges
      @(posedge clk); #3 reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, insn_valid}, 32'd0);
      chk("ar_addr", mem_addr, 32'h8002_0000);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("ar0_addr", mem_addr, 32'h8002_0000);
      repeat (2) @(negedge clk);
      chk("ar2_pc", insn_pc, 32'h8002_0000);
      repeat (3) @(negedge clk);
      // redirect to the top of the address space
      @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      @(posedge clk); #1 redirect_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("w3_pc", insn_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("w4_pc", insn_pc, 32'h0000_0000);
      chk("w4_insn", insn, mem_word(32'h0000_0000));
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
